// File: rtl/gbc_timer_if.sv
// Selected-device bus between the last-page decoder and the divider/timer block.
// The decoder side drives select, direction, index and write data; the timer returns read data.
interface gbc_timer_if;
    logic       i_Bus_Enable;
    logic       i_ReadWrite;
    logic [1:0] i_Register_Select;
    logic [7:0] i_Bus;
    logic [7:0] o_Bus;

    modport master (
        output i_Bus_Enable,
        output i_ReadWrite,
        output i_Register_Select,
        output i_Bus,
        input  o_Bus
    );

    modport slave (
        input  i_Bus_Enable,
        input  i_ReadWrite,
        input  i_Register_Select,
        input  i_Bus,
        output o_Bus
    );
endinterface

// File: rtl/gbc_timer.sv
// GBC divider/timer (DIV, TIMA, TMA, TAC at FF04-FF07) with the delayed-reload overflow sequence.
// o_Interrupt_Request feeds the timer bit of the interrupt controller.
module gbc_timer (
    input  logic       i_Clk,
    input  logic       i_nRst,
    input  logic       i_Enable,
    gbc_timer_if.slave bus,
    output logic       o_Interrupt_Request
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OVF    = 2'd1,
        ST_RELOAD = 2'd2
    } state_t;

    state_t      state_reg;
    logic [15:0] cnt_reg;
    logic [15:0] cnt_next;
    logic [7:0]  tima_reg;
    logic [7:0]  tima_inc;
    logic [7:0]  tma_reg;
    logic [7:0]  tma_next;
    logic [2:0]  tac_reg;
    logic [2:0]  tac_next;
    logic [1:0]  dly_reg;
    logic        irq_reg;
    logic        wr_any;
    logic        wr_div;
    logic        wr_tima;
    logic        wr_tma;
    logic        wr_tac;
    logic        tick;
    logic [7:0]  rd_data;

    // Timer input: enable bit ANDed with the counter bit chosen by the clock select.
    function automatic logic tap_sig(input logic [2:0] tac, input logic [15:0] cnt);
        logic b;
        case (tac[1:0])
            2'd0:    b = cnt[9];
            2'd1:    b = cnt[3];
            2'd2:    b = cnt[5];
            default: b = cnt[7];
        endcase
        return tac[2] & b;
    endfunction

    assign wr_any  = bus.i_Bus_Enable & bus.i_ReadWrite;
    assign wr_div  = wr_any & (bus.i_Register_Select == 2'd0);
    assign wr_tima = wr_any & (bus.i_Register_Select == 2'd1);
    assign wr_tma  = wr_any & (bus.i_Register_Select == 2'd2);
    assign wr_tac  = wr_any & (bus.i_Register_Select == 2'd3);

    assign cnt_next = wr_div ? 16'h0000 : cnt_reg + 16'd1;
    assign tac_next = wr_tac ? bus.i_Bus[2:0] : tac_reg;
    assign tma_next = wr_tma ? bus.i_Bus : tma_reg;
    assign tima_inc = tima_reg + 8'd1;

    // Falling edge of the tap signal across this edge; DIV/TAC writes can create one.
    assign tick = tap_sig(tac_reg, cnt_reg) & ~tap_sig(tac_next, cnt_next);

    always_comb begin
        rd_data = 8'h00;
        if (bus.i_Bus_Enable && !bus.i_ReadWrite) begin
            case (bus.i_Register_Select)
                2'd0:    rd_data = cnt_reg[15:8];
                2'd1:    rd_data = tima_reg;
                2'd2:    rd_data = tma_reg;
                default: rd_data = {5'b11111, tac_reg};
            endcase
        end
    end

    assign bus.o_Bus           = rd_data;
    assign o_Interrupt_Request = irq_reg;

    always_ff @(posedge i_Clk) begin
        if (!i_nRst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 16'h0000;
            tima_reg  <= 8'h00;
            tma_reg   <= 8'h00;
            tac_reg   <= 3'b000;
            dly_reg   <= 2'd0;
            irq_reg   <= 1'b0;
        end else if (i_Enable) begin
            cnt_reg <= cnt_next;
            tac_reg <= tac_next;
            tma_reg <= tma_next;
            irq_reg <= 1'b0;
            case (state_reg)
                ST_OVF: begin
                    if (wr_tima) begin
                        tima_reg  <= bus.i_Bus;
                        state_reg <= ST_IDLE;
                    end else if (dly_reg == 2'd3) begin
                        tima_reg  <= tma_next;
                        state_reg <= ST_RELOAD;
                        irq_reg   <= 1'b1;
                    end else begin
                        dly_reg <= dly_reg + 2'd1;
                        if (tick) tima_reg <= tima_inc;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    // In RELOAD a TMA write passes straight through to TIMA and TIMA writes are dropped.
                    if ((state_reg == ST_RELOAD) && wr_tma) begin
                        tima_reg <= bus.i_Bus;
                    end else if ((state_reg == ST_IDLE) && wr_tima) begin
                        tima_reg <= bus.i_Bus;
                    end else if (tick) begin
                        tima_reg <= tima_inc;
                        if (tima_reg == 8'hFF) begin
                            state_reg <= ST_OVF;
                            dly_reg   <= 2'd0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gbc_timer.sv
// Self-checking bench for gbc_timer: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural model of the timer rules.
module tb_gbc_timer;
    logic i_Clk = 1'b0;
    logic i_nRst = 1'b0;
    logic i_Enable = 1'b0;
    logic o_Interrupt_Request;

    gbc_timer_if bus_if ();

    gbc_timer dut (
        .i_Clk               (i_Clk),
        .i_nRst              (i_nRst),
        .i_Enable            (i_Enable),
        .bus                 (bus_if),
        .o_Interrupt_Request (o_Interrupt_Request)
    );

    always #5 i_Clk = ~i_Clk;

    int checks = 0;
    int failures = 0;
    bit started = 0;

    // Behavioural model state: ovf_age = enabled edges since the wrap, -1 when no overflow pending.
    logic [15:0] m_cnt = 16'h0;
    logic [7:0]  m_tima = 8'h0;
    logic [7:0]  m_tma = 8'h0;
    logic [2:0]  m_tac = 3'h0;
    int          m_ovf_age = -1;
    bit          m_reload = 0;
    bit          m_irq = 0;
    int          taps[4] = '{9, 3, 5, 7};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_sig(input logic [2:0] tac, input logic [15:0] cnt);
        return tac[2] && cnt[taps[tac[1:0]]];
    endfunction

    function automatic logic [7:0] m_read();
        if (!bus_if.i_Bus_Enable || bus_if.i_ReadWrite) return 8'h00;
        case (bus_if.i_Register_Select)
            2'd0:    return m_cnt[15:8];
            2'd1:    return m_tima;
            2'd2:    return m_tma;
            default: return {5'b11111, m_tac};
        endcase
    endfunction

    task automatic model_step();
        bit          wr, tick, was_reload;
        logic [1:0]  sel;
        logic [7:0]  d;
        logic [15:0] n_cnt;
        logic [2:0]  n_tac;
        if (!i_nRst) begin
            m_cnt = 16'h0; m_tima = 8'h0; m_tma = 8'h0; m_tac = 3'h0;
            m_ovf_age = -1; m_reload = 0; m_irq = 0;
        end else if (i_Enable) begin
            wr    = bus_if.i_Bus_Enable && bus_if.i_ReadWrite;
            sel   = bus_if.i_Register_Select;
            d     = bus_if.i_Bus;
            n_cnt = (wr && sel == 2'd0) ? 16'h0 : m_cnt + 16'h1;
            n_tac = (wr && sel == 2'd3) ? d[2:0] : m_tac;
            tick  = m_sig(m_tac, m_cnt) && !m_sig(n_tac, n_cnt);
            m_cnt = n_cnt;
            m_tac = n_tac;
            if (wr && sel == 2'd2) m_tma = d;
            m_irq = 0;
            was_reload = m_reload;
            m_reload = 0;
            if (m_ovf_age >= 0) begin
                if (wr && sel == 2'd1) begin
                    m_tima = d; m_ovf_age = -1;
                end else if (m_ovf_age == 3) begin
                    m_tima = m_tma; m_ovf_age = -1; m_reload = 1; m_irq = 1;
                end else begin
                    m_ovf_age++;
                    if (tick) m_tima = m_tima + 8'h1;
                end
            end else if (was_reload && wr && sel == 2'd2) begin
                m_tima = d;
            end else if (!was_reload && wr && sel == 2'd1) begin
                m_tima = d;
            end else if (tick) begin
                if (m_tima == 8'hFF) m_ovf_age = 0;
                m_tima = m_tima + 8'h1;
            end
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge i_Clk);
        if (started) begin
            chk("o_Bus", bus_if.o_Bus, m_read());
            chk("irq", {7'b0, o_Interrupt_Request}, {7'b0, m_irq});
        end
    end

    task automatic clk_edge();
        @(posedge i_Clk);
        model_step();
        #2;
    endtask

    task automatic cyc(input bit en, input bit be, input bit rw, input logic [1:0] sel, input logic [7:0] d);
        i_Enable = en;
        bus_if.i_Bus_Enable = be;
        bus_if.i_ReadWrite = rw;
        bus_if.i_Register_Select = sel;
        bus_if.i_Bus = d;
        clk_edge();
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] d);
        cyc(1, 1, 1, sel, d);
    endtask

    task automatic run(input int n);
        repeat (n) cyc(1, 0, 0, 2'd0, 8'h00);
    endtask

    // Combinational read during a disabled cycle, so no state moves.
    task automatic peek(input logic [1:0] sel, input logic [7:0] exp, input string name);
        i_Enable = 0;
        bus_if.i_Bus_Enable = 1;
        bus_if.i_ReadWrite = 0;
        bus_if.i_Register_Select = sel;
        bus_if.i_Bus = 8'h00;
        #1;
        chk(name, bus_if.o_Bus, exp);
        clk_edge();
    endtask

    task automatic do_reset(input bit en);
        i_nRst = 0;
        cyc(en, 0, 0, 2'd0, 8'h00);
        i_nRst = 1;
    endtask

    task automatic setup(input logic [7:0] tma, input logic [7:0] tima);
        do_reset(0);
        wr(2'd3, 8'h05);
        wr(2'd2, tma);
        wr(2'd1, tima);
        wr(2'd0, 8'h00);
    endtask

    initial begin
        bus_if.i_Bus_Enable = 0;
        bus_if.i_ReadWrite = 0;
        bus_if.i_Register_Select = 2'd0;
        bus_if.i_Bus = 8'h00;

        do_reset(0);
        started = 1;
        peek(2'd0, 8'h00, "rst_div");
        peek(2'd1, 8'h00, "rst_tima");
        peek(2'd2, 8'h00, "rst_tma");
        peek(2'd3, 8'hF8, "rst_tac");
        chk("rst_irq", {7'b0, o_Interrupt_Request}, 8'h00);

        // Tick and reload
        setup(8'h80, 8'hFE);
        run(16);
        peek(2'd1, 8'hFF, "tick16");
        run(16);
        peek(2'd1, 8'h00, "tick32_wrap");
        for (int k = 0; k < 3; k++) begin
            run(1);
            peek(2'd1, 8'h00, "ovf_hold");
            chk("ovf_irq_low", {7'b0, o_Interrupt_Request}, 8'h00);
        end
        run(1);
        peek(2'd1, 8'h80, "reload");
        chk("irq_pulse", {7'b0, o_Interrupt_Request}, 8'h01);
        chk("model_reload", m_tima, 8'h80);
        run(1);
        chk("irq_end", {7'b0, o_Interrupt_Request}, 8'h00);

        // DIV count and clear
        do_reset(0);
        run(512);
        peek(2'd0, 8'h02, "div512");
        chk("model_div", m_cnt[15:8], 8'h02);
        wr(2'd0, 8'h5A);
        peek(2'd0, 8'h00, "div_clear");
        run(255);
        peek(2'd0, 8'h00, "div_255");
        run(1);
        peek(2'd0, 8'h01, "div_256");

        // DIV-write glitch
        do_reset(0);
        wr(2'd3, 8'h05);
        wr(2'd1, 8'h10);
        run(6);
        peek(2'd1, 8'h10, "glitch_pre");
        wr(2'd0, 8'h00);
        peek(2'd1, 8'h11, "glitch_post");

        // Cancel in OVF
        setup(8'h80, 8'hFF);
        run(16);
        peek(2'd1, 8'h00, "cancel_wrap");
        run(1);
        wr(2'd1, 8'h33);
        peek(2'd1, 8'h33, "cancel_write");
        run(8);
        peek(2'd1, 8'h33, "cancel_hold");
        chk("cancel_irq", {7'b0, o_Interrupt_Request}, 8'h00);

        // TMA write in RELOAD
        setup(8'h80, 8'hFF);
        run(20);
        peek(2'd1, 8'h80, "rl_tima");
        chk("rl_irq", {7'b0, o_Interrupt_Request}, 8'h01);
        wr(2'd2, 8'h44);
        peek(2'd1, 8'h44, "rl_tma_tima");
        peek(2'd2, 8'h44, "rl_tma");

        // Bus isolation
        cyc(0, 0, 0, 2'd1, 8'h00);
        chk("iso_nosel", bus_if.o_Bus, 8'h00);
        cyc(0, 1, 1, 2'd1, 8'hAB);
        chk("iso_write", bus_if.o_Bus, 8'h00);
        wr(2'd3, 8'hFF);
        peek(2'd3, 8'hFF, "tac_ff");
        wr(2'd3, 8'h00);
        peek(2'd3, 8'hF8, "tac_00");

        // Reset mid-OVF
        setup(8'h80, 8'hFF);
        run(18);
        do_reset(1);
        peek(2'd0, 8'h00, "rovf_div");
        peek(2'd1, 8'h00, "rovf_tima");
        peek(2'd2, 8'h00, "rovf_tma");
        peek(2'd3, 8'hF8, "rovf_tac");
        run(8);
        chk("rovf_irq", {7'b0, o_Interrupt_Request}, 8'h00);

        // Random traffic against the model
        for (int i = 0; i < 6000; i++) begin
            bit en, be, rw;
            logic [1:0] sel;
            logic [7:0] d;
            en  = ($urandom % 8) != 0;
            be  = $urandom % 2;
            rw  = ($urandom % 8) == 0;
            sel = 2'($urandom % 4);
            d   = 8'($urandom);
            if (be && rw && sel == 2'd0 && ($urandom % 8) != 0) be = 0;
            if (sel == 2'd1 && ($urandom % 2) != 0) d = 8'hF8 | 8'($urandom % 8);
            if (sel == 2'd3 && ($urandom % 2) != 0) d[2:0] = 3'b101;
            i_nRst = ($urandom % 1000) != 0;
            cyc(en, be, rw, sel, d);
            i_nRst = 1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
